// File: rtl/bus_ctrl.sv
// Registered single-master bus controller: base/mask decode with fixed priority, held slave
// strobes, one-cycle master ack with registered read data and error reporting.
module bus_ctrl #(
    parameter int unsigned NUM_SLAVES = 6,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SEL_W      = 2,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {
        32'hFFC0_0000, 32'hFFFF_F000, 32'hFFFF_FC00,
        32'hFFFF_FE04, 32'hFFFF_FE08, 32'hFFFF_FE10
    },
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {
        32'hFFC0_0000, 32'hFFFF_F000, 32'hFFFF_FC00,
        32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFFC
    },
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            m_addr_i,
    input  logic [DATA_W-1:0]            m_data_i,
    input  logic [SEL_W-1:0]             m_sel_i,
    input  logic                         m_rd_i,
    input  logic                         m_we_i,
    output logic [DATA_W-1:0]            m_data_o,
    output logic                         m_ack_o,
    output logic                         m_err_o,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic [DATA_W-1:0]            s_data_o,
    output logic [SEL_W-1:0]             s_sel_o,
    output logic [NUM_SLAVES-1:0]        s_rd_o,
    output logic [NUM_SLAVES-1:0]        s_we_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
    input  logic [NUM_SLAVES-1:0]        s_ack_i
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StActive = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;

    logic [1:0]            state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  hit_any;
    logic [IDX_W-1:0]      hit_idx;
    logic [NUM_SLAVES-1:0] hit_oh;
    logic                  sel_ack;
    logic [DATA_W-1:0]     sel_data;
    logic                  tmo_fire;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        hit_oh  = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit_any   = 1'b1;
                hit_idx   = IDX_W'(i);
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_ack  = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ack  = s_ack_i[i];
                sel_data = s_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign tmo_fire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cnt_q    <= '0;
            m_data_o <= '0;
            m_ack_o  <= 1'b0;
            m_err_o  <= 1'b0;
            s_addr_o <= '0;
            s_data_o <= '0;
            s_sel_o  <= '0;
            s_rd_o   <= '0;
            s_we_o   <= '0;
        end else begin
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (m_rd_i | m_we_i) begin
                        s_addr_o <= m_addr_i;
                        s_data_o <= m_data_i;
                        s_sel_o  <= m_sel_i;
                        cnt_q    <= '0;
                        if ((m_rd_i & m_we_i) | !hit_any) begin
                            state_q  <= StResp;
                            m_ack_o  <= 1'b1;
                            m_err_o  <= 1'b1;
                            m_data_o <= '0;
                        end else begin
                            state_q <= StActive;
                            idx_q   <= hit_idx;
                            s_rd_o  <= m_rd_i ? hit_oh : '0;
                            s_we_o  <= m_we_i ? hit_oh : '0;
                        end
                    end
                end
                StActive: begin
                    // A selected-slave ack takes precedence over a timeout on the same edge.
                    if (sel_ack) begin
                        state_q <= StResp;
                        m_ack_o <= 1'b1;
                        s_rd_o  <= '0;
                        s_we_o  <= '0;
                        if (|s_rd_o) begin
                            m_data_o <= sel_data;
                        end
                    end else if (tmo_fire) begin
                        state_q  <= StResp;
                        m_ack_o  <= 1'b1;
                        m_err_o  <= 1'b1;
                        m_data_o <= '0;
                        s_rd_o   <= '0;
                        s_we_o   <= '0;
                    end else if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl: a transaction-level model sets the expected outputs for each
// cycle and a single negedge process compares every DUT output against them.
module tb_bus_ctrl;

    localparam int unsigned NS  = 6;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 2;
    localparam int unsigned TMO = 4;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0]    m_addr_i;
    logic [DW-1:0]    m_data_i;
    logic [SW-1:0]    m_sel_i;
    logic             m_rd_i;
    logic             m_we_i;
    logic [DW-1:0]    m_data_o;
    logic             m_ack_o;
    logic             m_err_o;
    logic [AW-1:0]    s_addr_o;
    logic [DW-1:0]    s_data_o;
    logic [SW-1:0]    s_sel_o;
    logic [NS-1:0]    s_rd_o;
    logic [NS-1:0]    s_we_o;
    logic [NS*DW-1:0] s_data_i;
    logic [NS-1:0]    s_ack_i;

    // Address map as the model sees it, slave 0 first.
    logic [31:0] base_tab [NS] = '{32'hFFFF_FE10, 32'hFFFF_FE08, 32'hFFFF_FE04,
                                   32'hFFFF_FC00, 32'hFFFF_F000, 32'hFFC0_0000};
    logic [31:0] mask_tab [NS] = '{32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFFC,
                                   32'hFFFF_FC00, 32'hFFFF_F000, 32'hFFC0_0000};

    bus_ctrl #(
        .NUM_SLAVES(NS),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .SEL_W     (SW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_addr_i(m_addr_i),
        .m_data_i(m_data_i),
        .m_sel_i (m_sel_i),
        .m_rd_i  (m_rd_i),
        .m_we_i  (m_we_i),
        .m_data_o(m_data_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_addr_o(s_addr_o),
        .s_data_o(s_data_o),
        .s_sel_o (s_sel_o),
        .s_rd_o  (s_rd_o),
        .s_we_o  (s_we_o),
        .s_data_i(s_data_i),
        .s_ack_i (s_ack_i)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [NS-1:0] exp_s_rd  = '0;
    logic [NS-1:0] exp_s_we  = '0;
    logic          exp_ack   = 1'b0;
    logic          exp_err   = 1'b0;
    logic [DW-1:0] exp_data  = '0;
    logic [AW-1:0] exp_addr  = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic [SW-1:0] exp_sel   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_slot(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & mask_tab[i]) == base_tab[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        check("m_ack_o",  64'(m_ack_o),  64'(exp_ack));
        check("m_err_o",  64'(m_err_o),  64'(exp_err));
        check("m_data_o", 64'(m_data_o), 64'(exp_data));
        check("s_rd_o",   64'(s_rd_o),   64'(exp_s_rd));
        check("s_we_o",   64'(s_we_o),   64'(exp_s_we));
        check("s_addr_o", 64'(s_addr_o), 64'(exp_addr));
        check("s_data_o", 64'(s_data_o), 64'(exp_wdata));
        check("s_sel_o",  64'(s_sel_o),  64'(exp_sel));
    end

    // ack_dly: strobe cycle (0 = first) in which the slave acks; negative means never.
    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                       input logic rd, input logic we, input int ack_dly,
                       input logic [31:0] rdata, input logic [NS-1:0] stray);
        int            k;
        bit            err_req;
        bit            timed_out;
        int            n_strobe;
        logic [NS-1:0] oh;
        k       = model_slot(a);
        err_req = (rd && we) || (k < 0);
        oh      = '0;
        if (k >= 0) oh[k] = 1'b1;
        m_addr_i = a;
        m_data_i = d;
        m_sel_i  = s;
        m_rd_i   = rd;
        m_we_i   = we;
        s_ack_i  = '0;
        s_data_i = {NS{~rdata}};
        if (k >= 0) s_data_i[k*DW +: DW] = rdata;
        exp_ack  = 1'b0;
        exp_err  = 1'b0;
        exp_s_rd = '0;
        exp_s_we = '0;
        @(posedge clk); #1;
        exp_addr  = a;
        exp_wdata = d;
        exp_sel   = s;
        if (err_req) begin
            exp_ack  = 1'b1;
            exp_err  = 1'b1;
            exp_data = '0;
        end else begin
            timed_out = (ack_dly < 0) || (ack_dly >= int'(TMO));
            n_strobe  = timed_out ? int'(TMO) : ack_dly + 1;
            for (int j = 0; j < n_strobe; j++) begin
                exp_s_rd = rd ? oh : '0;
                exp_s_we = we ? oh : '0;
                s_ack_i  = (j == ack_dly) ? oh : (stray & ~oh);
                @(posedge clk); #1;
            end
            s_ack_i  = '0;
            exp_s_rd = '0;
            exp_s_we = '0;
            exp_ack  = 1'b1;
            exp_err  = timed_out;
            if (timed_out) exp_data = '0;
            else if (rd) exp_data = rdata;
        end
        @(posedge clk); #1;
        exp_ack = 1'b0;
        exp_err = 1'b0;
        m_rd_i  = 1'b0;
        m_we_i  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        m_addr_i = 32'hFFFF_FE04;
        m_data_i = '0;
        m_sel_i  = '0;
        m_rd_i   = 1'b1;
        m_we_i   = 1'b0;
        s_data_i = '0;
        s_ack_i  = '0;

        // Model decode pinned against hand-derived slots.
        check("model_fe10", 64'(model_slot(32'hFFFF_FE10)), 64'(0));
        check("model_fe0c", 64'(model_slot(32'hFFFF_FE0C)), 64'(1));
        check("model_f800", 64'(model_slot(32'hFFFF_F800)), 64'(4));
        check("model_fe14", 64'(model_slot(32'hFFFF_FE14)), 64'(3));
        check("model_1000", 64'(model_slot(32'h0000_1000)), 64'(-1));

        repeat (3) @(posedge clk);
        #1;
        m_rd_i = 1'b0;
        rst    = 1'b1;

        txn(32'hFFFF_FE04, 32'h0, 2'd2, 1'b1, 1'b0, 0, 32'h0000_1234, '0);
        check("first_read_data", 64'(m_data_o), 64'h0000_1234);

        txn(32'hFFFF_FE0C, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b1, 0, 32'h0, '0);
        check("write_keeps_rdata", 64'(m_data_o), 64'h0000_1234);
        txn(32'hFFFF_F800, 32'h1111_2222, 2'd1, 1'b0, 1'b1, 1, 32'h0, '0);
        txn(32'hFFFF_FE10, 32'h3333_4444, 2'd0, 1'b0, 1'b1, 0, 32'h0, '0);
        txn(32'hFFFF_FE14, 32'h0, 2'd2, 1'b1, 1'b0, 2, 32'h5A5A_0314, '0);

        txn(32'h0000_1000, 32'h0, 2'd2, 1'b1, 1'b0, 0, 32'h0, '0);
        check("decode_err_data", 64'(m_data_o), 64'h0);
        txn(32'hFFFF_FE04, 32'h7777_0000, 2'd2, 1'b1, 1'b1, 0, 32'h0, '0);

        txn(32'hFFC0_0000, 32'h0, 2'd2, 1'b1, 1'b0, -1, 32'hBAD0_0005, '0);
        s_ack_i = 6'b100000;
        @(posedge clk); #1;
        s_ack_i = '0;
        @(posedge clk); #1;

        txn(32'hFFFF_FC00, 32'h0, 2'd2, 1'b1, 1'b0, 3, 32'hC0DE_0003, 6'b000010);
        check("slow_rdata", 64'(m_data_o), 64'hC0DE_0003);

        // Reset while a read to slot 5 is outstanding.
        m_addr_i = 32'hFFC0_0010;
        m_rd_i   = 1'b1;
        @(posedge clk); #1;
        exp_addr  = 32'hFFC0_0010;
        exp_wdata = m_data_i;
        exp_sel   = m_sel_i;
        exp_s_rd  = 6'b100000;
        @(posedge clk); #1;
        #2;
        rst = 1'b0;
        #1;
        check("async_strobe_drop", 64'(s_rd_o), 64'h0);
        check("async_no_ack", 64'(m_ack_o), 64'h0);
        m_rd_i    = 1'b0;
        exp_s_rd  = '0;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_sel   = '0;
        exp_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        txn(32'hFFFF_FE08, 32'h0, 2'd2, 1'b1, 1'b0, 1, 32'h0BAD_F00D, '0);

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
